// File: rtl/dma_2a03_multi.sv
// dma_2a03_multi: multi-channel page-copy DMA sharing the CPU bus with cpu_2a03.
// A CPU write to REG_BASE+i loads channel i's source page and marks it pending.
// The CPU is then halted through rdy, and LEN bytes are copied from {page,idx}
// to the channel's fixed destination address. Reads happen only in even (parity=0)
// cycles and writes only in odd cycles, which matches the 2a03 get/put alignment.
// Ports:
//   clock, nreset              CPU clock, async active-low reset
//   cpu_addr/cpu_data/cpu_rw   snooped CPU bus (register hits)
//   data_in                    system read data
//   rdy                        1 = CPU runs, 0 = CPU halted
//   bus_owner                  1 = DMA drives addr/data_out/rw
//   addr, data_out, rw         DMA bus signals (idle: 0, 0, 1)
//   busy[i], done[i]           channel pending/active; 1-cycle pulse after final write
module dma_2a03_multi #(
  parameter int unsigned          NUM_CH     = 1,
  parameter int unsigned          LEN        = 256,
  parameter logic [15:0]          REG_BASE   = 16'h4014,
  parameter logic [16*NUM_CH-1:0] DEST_ADDRS = (16*NUM_CH)'(16'h2004)
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_data,
  input  logic              cpu_rw,
  input  logic [7:0]        data_in,
  output logic              rdy,
  output logic              bus_owner,
  output logic [15:0]       addr,
  output logic [7:0]        data_out,
  output logic              rw,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0]  LAST_IDX = 8'(LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]        state, state_n;
  logic              parity;
  logic [NUM_CH-1:0] pending, pending_n;
  logic [7:0]        page   [NUM_CH];
  logic [7:0]        page_n [NUM_CH];
  logic [CH_W-1:0]   ch, ch_n, sel;
  logic [7:0]        idx, idx_n;
  logic [NUM_CH-1:0] hit;
  logic              active_n;
  logic [7:0]        cur_page;
  logic [15:0]       cur_dest;

  logic              rdy_n, bus_owner_n, rw_n;
  logic [15:0]       addr_n;
  logic [7:0]        data_out_n;
  logic [NUM_CH-1:0] busy_n, done_n;

  // Lowest-index set bit; channels with lower index win arbitration.
  function automatic logic [CH_W-1:0] lowest(input logic [NUM_CH-1:0] v);
    lowest = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--)
      if (v[i]) lowest = CH_W'(i);
  endfunction

  function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] c);
    onehot = '0;
    for (int i = 0; i < int'(NUM_CH); i++)
      if (c == CH_W'(i)) onehot[i] = 1'b1;
  endfunction

  // Next-state, bookkeeping and next-output logic.
  always_comb begin
    state_n   = state;
    pending_n = pending;
    page_n    = page;
    ch_n      = ch;
    idx_n     = idx;
    done_n    = '0;
    hit       = '0;
    sel       = lowest(pending);

    for (int i = 0; i < int'(NUM_CH); i++)
      hit[i] = !cpu_rw && !bus_owner && (cpu_addr == REG_BASE + 16'(i));

    case (state)
      // A hit in this very cycle already counts as pending.
      S_IDLE: if ((pending | hit) != '0) state_n = S_HALT;
      // The 6502 ignores RDY during writes, so wait for a read cycle.
      S_HALT: begin
        if (cpu_rw) begin
          state_n   = parity ? S_READ : S_ALIGN;
          ch_n      = sel;
          pending_n = pending & ~onehot(sel);
        end
      end
      S_ALIGN: state_n = S_READ;
      S_READ:  state_n = S_WRITE;
      S_WRITE: begin
        if (idx == LAST_IDX) begin
          idx_n  = '0;
          done_n = onehot(ch);
          // Back-to-back channels keep the CPU halted and skip HALT.
          if (pending != '0) begin
            state_n   = S_READ;
            ch_n      = sel;
            pending_n = pending & ~onehot(sel);
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          idx_n   = idx + 8'd1;
          state_n = S_READ;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Hits never coincide with a channel selection (selection needs cpu_rw=1 or bus_owner=1).
    pending_n = pending_n | hit;
    for (int i = 0; i < int'(NUM_CH); i++)
      if (hit[i]) page_n[i] = cpu_data;

    cur_page = '0;
    cur_dest = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ch_n == CH_W'(i)) begin
        cur_page = page_n[i];
        cur_dest = DEST_ADDRS[16*i +: 16];
      end
    end

    active_n    = (state_n == S_ALIGN) || (state_n == S_READ) || (state_n == S_WRITE);
    rdy_n       = (state_n == S_IDLE);
    bus_owner_n = (state_n == S_READ) || (state_n == S_WRITE);
    addr_n      = '0;
    data_out_n  = '0;
    rw_n        = 1'b1;
    if (state_n == S_READ) begin
      addr_n = {cur_page, idx_n};
    end else if (state_n == S_WRITE) begin
      // WRITE always follows READ, so data_in here is the byte just read.
      addr_n     = cur_dest;
      data_out_n = data_in;
      rw_n       = 1'b0;
    end
    busy_n = pending_n | (active_n ? onehot(ch_n) : '0);
  end

  // State, bookkeeping and output registers.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state     <= S_IDLE;
      parity    <= 1'b0;
      pending   <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) page[i] <= '0;
      ch        <= '0;
      idx       <= '0;
      rdy       <= 1'b1;
      bus_owner <= 1'b0;
      addr      <= '0;
      data_out  <= '0;
      rw        <= 1'b1;
      busy      <= '0;
      done      <= '0;
    end else begin
      state     <= state_n;
      parity    <= !parity;
      pending   <= pending_n;
      for (int i = 0; i < int'(NUM_CH); i++) page[i] <= page_n[i];
      ch        <= ch_n;
      idx       <= idx_n;
      rdy       <= rdy_n;
      bus_owner <= bus_owner_n;
      addr      <= addr_n;
      data_out  <= data_out_n;
      rw        <= rw_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_dma_2a03_multi.sv
// Bench for dma_2a03_multi: three instances (default, 2 channels x 4 bytes, 1 byte).
module tb_dma_2a03_multi;
  localparam int LEN_A = 256;
  localparam int LEN_B = 4;

  typedef struct { int cyc; bit we; logic [15:0] addr; logic [7:0] data; } op_t;
  typedef struct { logic [7:0] page; int wpar; int extra; int exp_low; } vec_t;

  logic clock  = 1'b0;
  logic nreset = 1'b0;
  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;

  always #5 clock = ~clock;

  // Cycle index since reset release; the DMA's parity equals cyc[0].
  always @(posedge clock or negedge nreset)
    if (!nreset) cyc <= 0;
    else         cyc <= cyc + 1;

  // Memory contents seen on the read bus.
  function automatic logic [7:0] memf(input logic [15:0] a);
    return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic int enc(input bit we, input logic [15:0] a, input logic [7:0] d);
    return int'({7'd0, we, a, d});
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // ---------------- instance A: default parameters
  logic [15:0] a_cpu_addr = 16'h8000;
  logic [7:0]  a_cpu_data = 8'h00;
  logic        a_cpu_rw   = 1'b1;
  logic [7:0]  a_data_in;
  logic        a_rdy, a_bo, a_rw;
  logic [15:0] a_addr;
  logic [7:0]  a_dout;
  logic [0:0]  a_busy, a_done;
  assign a_data_in = memf(a_addr);

  dma_2a03_multi u_a (
    .clock(clock), .nreset(nreset), .cpu_addr(a_cpu_addr), .cpu_data(a_cpu_data),
    .cpu_rw(a_cpu_rw), .data_in(a_data_in), .rdy(a_rdy), .bus_owner(a_bo),
    .addr(a_addr), .data_out(a_dout), .rw(a_rw), .busy(a_busy), .done(a_done));

  // ---------------- instance B: two channels, 4 bytes each
  logic [15:0] b_cpu_addr = 16'h8000;
  logic [7:0]  b_cpu_data = 8'h00;
  logic        b_cpu_rw   = 1'b1;
  logic [7:0]  b_data_in;
  logic        b_rdy, b_bo, b_rw;
  logic [15:0] b_addr;
  logic [7:0]  b_dout;
  logic [1:0]  b_busy, b_done;
  assign b_data_in = memf(b_addr);

  dma_2a03_multi #(.NUM_CH(2), .LEN(LEN_B), .DEST_ADDRS({16'h2007, 16'h2004})) u_b (
    .clock(clock), .nreset(nreset), .cpu_addr(b_cpu_addr), .cpu_data(b_cpu_data),
    .cpu_rw(b_cpu_rw), .data_in(b_data_in), .rdy(b_rdy), .bus_owner(b_bo),
    .addr(b_addr), .data_out(b_dout), .rw(b_rw), .busy(b_busy), .done(b_done));

  // ---------------- instance C: single-byte transfers
  logic [15:0] c_cpu_addr = 16'h8000;
  logic [7:0]  c_cpu_data = 8'h00;
  logic        c_cpu_rw   = 1'b1;
  logic [7:0]  c_data_in;
  logic        c_rdy, c_bo, c_rw;
  logic [15:0] c_addr;
  logic [7:0]  c_dout;
  logic [0:0]  c_busy, c_done;
  assign c_data_in = memf(c_addr);

  dma_2a03_multi #(.LEN(1)) u_c (
    .clock(clock), .nreset(nreset), .cpu_addr(c_cpu_addr), .cpu_data(c_cpu_data),
    .cpu_rw(c_cpu_rw), .data_in(c_data_in), .rdy(c_rdy), .bus_owner(c_bo),
    .addr(c_addr), .data_out(c_dout), .rw(c_rw), .busy(c_busy), .done(c_done));

  // ---------------- bus monitors (sampled mid-cycle)
  op_t  a_obs[$];
  int   a_low = 0, a_done_cnt = 0, a_done_cyc = -1, a_rise_cyc = -1, a_par_bad = 0, a_side_bad = 0;
  logic a_prev_rdy = 1'b1;
  always @(negedge clock) if (nreset) begin
    if (!a_rdy) a_low <= a_low + 1;
    if (a_bo) a_obs.push_back('{cyc, !a_rw, a_addr, a_rw ? 8'h00 : a_dout});
    if (a_bo && (a_rw == cyc[0])) a_par_bad <= a_par_bad + 1;
    if ((!a_bo && (a_addr != 16'h0 || a_dout != 8'h0 || !a_rw)) || (a_bo && !a_cpu_rw))
      a_side_bad <= a_side_bad + 1;
    if (a_done != 1'b0) begin a_done_cnt <= a_done_cnt + 1; a_done_cyc <= cyc; end
    if (a_rdy && !a_prev_rdy) a_rise_cyc <= cyc;
    a_prev_rdy <= a_rdy;
  end

  op_t b_obs[$];
  int  b_low = 0, b_d0_cnt = 0, b_d1_cnt = 0, b_par_bad = 0, b_side_bad = 0;
  always @(negedge clock) if (nreset) begin
    if (!b_rdy) b_low <= b_low + 1;
    if (b_bo) b_obs.push_back('{cyc, !b_rw, b_addr, b_rw ? 8'h00 : b_dout});
    if (b_bo && (b_rw == cyc[0])) b_par_bad <= b_par_bad + 1;
    if ((!b_bo && (b_addr != 16'h0 || b_dout != 8'h0 || !b_rw)) || (b_bo && !b_cpu_rw))
      b_side_bad <= b_side_bad + 1;
    if (b_done[0]) b_d0_cnt <= b_d0_cnt + 1;
    if (b_done[1]) b_d1_cnt <= b_d1_cnt + 1;
  end

  op_t  c_obs[$];
  int   c_low = 0, c_done_cnt = 0, c_done_cyc = -1, c_rise_cyc = -1, c_par_bad = 0;
  logic c_prev_rdy = 1'b1;
  always @(negedge clock) if (nreset) begin
    if (!c_rdy) c_low <= c_low + 1;
    if (c_bo) c_obs.push_back('{cyc, !c_rw, c_addr, c_rw ? 8'h00 : c_dout});
    if (c_bo && (c_rw == cyc[0])) c_par_bad <= c_par_bad + 1;
    if (c_done != 1'b0) begin c_done_cnt <= c_done_cnt + 1; c_done_cyc <= cyc; end
    if (c_rdy && !c_prev_rdy) c_rise_cyc <= cyc;
    c_prev_rdy <= c_rdy;
  end

  task automatic a_idle();
    a_cpu_rw = 1'b1; a_cpu_addr = 16'h8000; a_cpu_data = 8'h00;
  endtask

  task automatic b_idle();
    b_cpu_rw = 1'b1; b_cpu_addr = 16'h8000; b_cpu_data = 8'h00;
  endtask

  task automatic c_idle();
    c_cpu_rw = 1'b1; c_cpu_addr = 16'h8000; c_cpu_data = 8'h00;
  endtask

  // One channel-0 transfer on A: register write in a cycle of parity wpar, followed by
  // `extra` CPU write cycles. Checks the bus trace against the copy rule; returns rdy-low cycles.
  task automatic run_a(input logic [7:0] page, input int wpar, input int extra,
                       output int w, output int low);
    int o0, l0, d0, t, last;
    op_t rd, wr;
    o0 = a_obs.size(); l0 = a_low; d0 = a_done_cnt;
    @(posedge clock); #1; a_idle();
    while (cyc % 2 != wpar) begin @(posedge clock); #1; end
    w = cyc;
    a_cpu_rw = 1'b0; a_cpu_addr = 16'h4014; a_cpu_data = page;
    for (int k = 0; k < extra; k++) begin
      @(posedge clock); #1; a_cpu_addr = 16'h0300; a_cpu_data = 8'(k);
    end
    @(posedge clock); #1; a_idle();
    t = 0;
    while (a_done_cnt == d0 && t < 3000) begin @(posedge clock); #1; t++; end
    chk("a_done_timeout", int'(t < 3000), 1);
    repeat (4) @(posedge clock);
    #1;
    low = a_low - l0;
    chk("a_done_count", a_done_cnt - d0, 1);
    chk("a_op_count", a_obs.size() - o0, 2 * LEN_A);
    if (a_obs.size() - o0 == 2 * LEN_A) begin
      for (int k = 0; k < LEN_A; k++) begin
        rd = a_obs[o0 + 2*k];
        wr = a_obs[o0 + 2*k + 1];
        chk("a_read", enc(rd.we, rd.addr, rd.data), enc(1'b0, {page, 8'(k)}, 8'h00));
        chk("a_write", enc(wr.we, wr.addr, wr.data), enc(1'b1, 16'h2004, memf({page, 8'(k)})));
      end
      last = a_obs[a_obs.size() - 1].cyc;
      chk("a_done_cycle", a_done_cyc, last + 1);
      chk("a_rdy_rise_cycle", a_rise_cyc, last + 1);
    end
  endtask

  initial begin
    vec_t tbl[5];
    int   w, low, e_low, o0, l0, d0, d1, t, extra, wpar, last;
    logic [7:0] pg;
    op_t  o;

    // {page, parity of the register-write cycle, extra CPU writes, expected rdy-low cycles}
    tbl[0] = '{8'h02, 0, 0, 513};
    tbl[1] = '{8'h02, 1, 0, 514};
    tbl[2] = '{8'h80, 0, 1, 515};
    tbl[3] = '{8'hFF, 1, 1, 514};
    tbl[4] = '{8'h00, 0, 2, 515};

    repeat (3) @(negedge clock);
    chk("rst_rdy", int'(a_rdy), 1);
    chk("rst_bus_owner", int'(a_bo), 0);
    chk("rst_addr", int'(a_addr), 0);
    chk("rst_data_out", int'(a_dout), 0);
    chk("rst_rw", int'(a_rw), 1);
    chk("rst_busy_done", int'({b_busy, b_done, a_busy, a_done}), 0);
    @(negedge clock); #1; nreset = 1'b1;
    repeat (3) @(posedge clock);

    // Directed table on A.
    for (int i = 0; i < 5; i++) begin
      run_a(tbl[i].page, tbl[i].wpar, tbl[i].extra, w, low);
      chk("a_tbl_rdy_low", low, tbl[i].exp_low);
    end

    // Randomized transfers on A against the cycle-count rule.
    for (int i = 0; i < 3; i++) begin
      pg    = 8'($urandom);
      wpar  = int'($urandom_range(1, 0));
      extra = int'($urandom_range(3, 0));
      run_a(pg, wpar, extra, w, low);
      e_low = 1 + extra + ((w + extra) % 2) + 2 * LEN_A;
      chk("a_rand_rdy_low", low, e_low);
    end

    // B: channel 1 then channel 0 inside one HALT; channel 0 must run first.
    o0 = b_obs.size(); l0 = b_low; d0 = b_d0_cnt; d1 = b_d1_cnt;
    @(posedge clock); #1;
    w = cyc;
    b_cpu_rw = 1'b0; b_cpu_addr = 16'h4015; b_cpu_data = 8'h11;
    @(posedge clock); #1; b_cpu_addr = 16'h4014; b_cpu_data = 8'h22;
    @(posedge clock); #1; b_idle();
    @(negedge clock);
    chk("b_busy_halt", int'(b_busy), 3);
    chk("b_rdy_halt", int'(b_rdy), 0);
    t = 0;
    while (b_d1_cnt == d1 && t < 200) begin @(posedge clock); #1; t++; end
    chk("b_done_timeout", int'(t < 200), 1);
    repeat (4) @(posedge clock);
    #1;
    chk("b_rdy_low", b_low - l0, 2 + ((w + 1) % 2) + 4 * LEN_B);
    chk("b_done0_count", b_d0_cnt - d0, 1);
    chk("b_done1_count", b_d1_cnt - d1, 1);
    chk("b_op_count", b_obs.size() - o0, 4 * LEN_B);
    if (b_obs.size() - o0 == 4 * LEN_B) begin
      for (int c = 0; c < 2; c++) begin
        pg = (c == 0) ? 8'h22 : 8'h11;
        for (int k = 0; k < LEN_B; k++) begin
          o = b_obs[o0 + 2*LEN_B*c + 2*k];
          chk("b_read", enc(o.we, o.addr, o.data), enc(1'b0, {pg, 8'(k)}, 8'h00));
          o = b_obs[o0 + 2*LEN_B*c + 2*k + 1];
          chk("b_write", enc(o.we, o.addr, o.data),
              enc(1'b1, (c == 0) ? 16'h2004 : 16'h2007, memf({pg, 8'(k)})));
        end
      end
      chk("b_no_gap", b_obs[b_obs.size() - 1].cyc - b_obs[o0].cyc, 4 * LEN_B - 1);
    end

    // C: single-byte transfer.
    o0 = c_obs.size(); l0 = c_low; d0 = c_done_cnt;
    @(posedge clock); #1;
    w = cyc;
    c_cpu_rw = 1'b0; c_cpu_addr = 16'h4014; c_cpu_data = 8'h33;
    @(posedge clock); #1; c_idle();
    t = 0;
    while (c_done_cnt == d0 && t < 50) begin @(posedge clock); #1; t++; end
    chk("c_done_timeout", int'(t < 50), 1);
    repeat (3) @(posedge clock);
    #1;
    chk("c_rdy_low", c_low - l0, 1 + (w % 2) + 2);
    chk("c_done_count", c_done_cnt - d0, 1);
    chk("c_op_count", c_obs.size() - o0, 2);
    if (c_obs.size() - o0 == 2) begin
      o = c_obs[o0];
      chk("c_read", enc(o.we, o.addr, o.data), enc(1'b0, 16'h3300, 8'h00));
      o = c_obs[o0 + 1];
      chk("c_write", enc(o.we, o.addr, o.data), enc(1'b1, 16'h2004, memf(16'h3300)));
      last = o.cyc;
      chk("c_done_cycle", c_done_cyc, last + 1);
      chk("c_rdy_rise_cycle", c_rise_cyc, last + 1);
    end

    // A: reset in the middle of a READ aborts the transfer for good.
    @(posedge clock); #1;
    a_cpu_rw = 1'b0; a_cpu_addr = 16'h4014; a_cpu_data = 8'h05;
    @(posedge clock); #1; a_idle();
    repeat (20) @(negedge clock);
    t = 0;
    while (!(a_bo && a_rw) && t < 10) begin @(negedge clock); t++; end
    chk("a_reached_read", int'(a_bo && a_rw), 1);
    #2 nreset = 1'b0;
    #1;
    chk("mid_rst_rdy", int'(a_rdy), 1);
    chk("mid_rst_bus_owner", int'(a_bo), 0);
    chk("mid_rst_busy", int'(a_busy), 0);
    chk("mid_rst_addr_rw", int'({a_addr, a_rw}), 1);
    @(negedge clock); #1; nreset = 1'b1;
    o0 = a_obs.size(); l0 = a_low;
    repeat (20) @(posedge clock);
    #1;
    chk("post_rst_bus_cycles", a_obs.size() - o0, 0);
    chk("post_rst_rdy_low", a_low - l0, 0);

    chk("a_parity_rule", a_par_bad, 0);
    chk("a_idle_side", a_side_bad, 0);
    chk("b_parity_rule", b_par_bad, 0);
    chk("b_idle_side", b_side_bad, 0);
    chk("c_parity_rule", c_par_bad, 0);
    chk("c_busy_idle", int'(c_busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
